// File: rtl/iob_intr_pkt_sched_pkg.sv
// Shared constants, header field layout and FSM encoding
// for the interrupt packet scheduler.
package iob_intr_pkt_sched_pkg;

  localparam logic [7:0] MSG_TYPE_INTERRUPT = 8'd32;
  localparam logic [3:0] NOC_FBITS_L1       = 4'b0000;
  localparam logic [7:0] PKT_LEN_ONE        = 8'd1;

  localparam int CHIPID_HI = 63;
  localparam int CHIPID_LO = 50;
  localparam int DST_X_HI  = 49;
  localparam int DST_X_LO  = 42;
  localparam int DST_Y_HI  = 41;
  localparam int DST_Y_LO  = 34;
  localparam int FBITS_HI  = 33;
  localparam int FBITS_LO  = 30;
  localparam int LENGTH_HI = 29;
  localparam int LENGTH_LO = 22;
  localparam int TYPE_HI   = 21;
  localparam int TYPE_LO   = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PLD  = 2'd2
  } state_t;

endpackage

// File: rtl/iob_intr_pkt_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the
// pointer wins; pointer moves past the winner on grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW:0]   slot;

  // Scan requesters starting from the pointer, wrapping.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr} + (IW+1)'(k);
      if (slot >= (IW+1)'(N)) slot = slot - (IW+1)'(N);
      if (!found && req[slot[IW-1:0]]) begin
        found = 1'b1;
        idx   = slot[IW-1:0];
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

  // Advance pointer past the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/iob_intr_pkt_sched.sv
// Arbitrates requesters onto one NoC port as two-flit
// interrupt packets, dropping requests with bad tile ids.
module iob_intr_pkt_sched
  import iob_intr_pkt_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NUM_TILES_X = 8,
  parameter int NUM_TILES   = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_val,
  output logic [NUM_REQ-1:0]    req_rdy,
  input  logic [NUM_REQ*32-1:0] req_tileid,
  input  logic [NUM_REQ*64-1:0] req_data,
  output logic                  noc_out_val,
  input  logic                  noc_out_rdy,
  output logic [63:0]           noc_out_data,
  output logic                  err_bad_tile,
  output logic                  busy,
  output logic [CNT_W-1:0]      pkt_sent_cnt,
  output logic [CNT_W-1:0]      pkt_drop_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  state_t        state;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0] gidx;
  logic          gfound;
  logic          idle;
  logic          grant;
  logic [31:0]   sel_tile;
  logic [63:0]   sel_data;
  logic          bad;
  logic [63:0]   hdr_flit;
  logic [63:0]   pld_flit;
  logic [63:0]   pld_q;

  assign idle  = (state == IDLE);
  assign grant = idle && gfound;
  assign busy  = !idle;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_val),
    .en    (idle),
    .gnt   (gnt),
    .idx   (gidx),
    .found (gfound)
  );

  assign req_rdy  = idle ? gnt : '0;
  assign sel_tile = req_tileid[32*int'(gidx) +: 32];
  assign sel_data = req_data[64*int'(gidx) +: 64];
  assign bad      = (sel_tile >= 32'(NUM_TILES));

  // Format header and payload flits of the granted request.
  always_comb begin
    hdr_flit = '0;
    hdr_flit[CHIPID_HI:CHIPID_LO] = '0;
    hdr_flit[DST_X_HI:DST_X_LO] =
      8'(sel_tile % 32'(NUM_TILES_X));
    hdr_flit[DST_Y_HI:DST_Y_LO] =
      8'(sel_tile / 32'(NUM_TILES_X));
    hdr_flit[FBITS_HI:FBITS_LO]   = NOC_FBITS_L1;
    hdr_flit[LENGTH_HI:LENGTH_LO] = PKT_LEN_ONE;
    hdr_flit[TYPE_HI:TYPE_LO]     = MSG_TYPE_INTERRUPT;
    pld_flit = {sel_data[63:16], 7'b0, sel_data[8:0]};
  end

  // Packet FSM with registered flit, error and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      noc_out_val  <= 1'b0;
      noc_out_data <= '0;
      pld_q        <= '0;
      err_bad_tile <= 1'b0;
      pkt_sent_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      err_bad_tile <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant && bad) begin
            err_bad_tile <= 1'b1;
            if (pkt_drop_cnt != '1)
              pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
          end else if (grant) begin
            state        <= HDR;
            noc_out_val  <= 1'b1;
            noc_out_data <= hdr_flit;
            pld_q        <= pld_flit;
          end
        end
        HDR: begin
          if (noc_out_rdy) begin
            state        <= PLD;
            noc_out_data <= pld_q;
          end
        end
        PLD: begin
          if (noc_out_rdy) begin
            state        <= IDLE;
            noc_out_val  <= 1'b0;
            noc_out_data <= '0;
            if (pkt_sent_cnt != '1)
              pkt_sent_cnt <= pkt_sent_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          noc_out_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_intr_pkt_sched.sv
// Directed self-checking bench for iob_intr_pkt_sched.
// Main instance uses defaults; a second has CNT_W=4.
module tb_iob_intr_pkt_sched;
  import iob_intr_pkt_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_val = '0;
  logic [3:0]   req_rdy;
  logic [127:0] req_tileid = '0;
  logic [255:0] req_data = '0;
  logic         noc_out_val;
  logic         noc_out_rdy = 1'b1;
  logic [63:0]  noc_out_data;
  logic         err_bad_tile;
  logic         busy;
  logic [15:0]  pkt_sent_cnt;
  logic [15:0]  pkt_drop_cnt;

  logic [3:0]   s_req_val = '0;
  logic [3:0]   s_req_rdy;
  logic [127:0] s_req_tileid = 128'd3;
  logic [255:0] s_req_data = 256'h1234;
  logic         s_val;
  logic [63:0]  s_data;
  logic         s_err;
  logic         s_busy;
  logic [3:0]   s_sent;
  logic [3:0]   s_drop;

  int ntests = 0;
  int nfail = 0;
  int flit_cnt = 0;
  int s_flit_cnt = 0;

  always #5 clk = ~clk;

  iob_intr_pkt_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_tileid(req_tileid), .req_data(req_data),
    .noc_out_val(noc_out_val), .noc_out_rdy(noc_out_rdy),
    .noc_out_data(noc_out_data),
    .err_bad_tile(err_bad_tile), .busy(busy),
    .pkt_sent_cnt(pkt_sent_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  iob_intr_pkt_sched #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req_val(s_req_val), .req_rdy(s_req_rdy),
    .req_tileid(s_req_tileid), .req_data(s_req_data),
    .noc_out_val(s_val), .noc_out_rdy(1'b1),
    .noc_out_data(s_data),
    .err_bad_tile(s_err), .busy(s_busy),
    .pkt_sent_cnt(s_sent), .pkt_drop_cnt(s_drop)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt   <= 0;
      s_flit_cnt <= 0;
    end else begin
      if (noc_out_val && noc_out_rdy) flit_cnt <= flit_cnt + 1;
      if (s_val) s_flit_cnt <= s_flit_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (noc_out_val && $isunknown(noc_out_data)) begin
      nfail++;
      $display("FAIL xcheck: noc_out_data=%h while valid", noc_out_data);
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] x,
                                      input logic [7:0] y);
    return (64'(x) << 42) | (64'(y) << 34) |
           (64'(NOC_FBITS_L1) << 30) | (64'd1 << 22) |
           (64'(MSG_TYPE_INTERRUPT) << 14);
  endfunction

  typedef struct {
    int          ri;
    logic [31:0] tile;
    logic [63:0] data;
    logic        bad;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [63:0] pld;
  } vec_t;

  vec_t vt[6];
  int   exp_sent;
  int   exp_drop;
  int   gcount[4];
  logic [3:0] eg;

  initial begin
    vt[0] = '{0, 32'd10, 64'h0123_4567_89AB_CDEF, 1'b0,
              8'd2, 8'd1, 64'h0123_4567_89AB_01EF};
    vt[1] = '{1, 32'd63, 64'hFEDC_BA98_7654_3210, 1'b0,
              8'd7, 8'd7, 64'hFEDC_BA98_7654_0010};
    vt[2] = '{2, 32'd64, 64'h5555_5555_5555_5555, 1'b1,
              8'd0, 8'd0, 64'h0};
    vt[3] = '{3, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              8'd0, 8'd0, 64'hFFFF_FFFF_FFFF_01FF};
    vt[4] = '{1, 32'hFFFF_FFFF, 64'h1, 1'b1,
              8'd0, 8'd0, 64'h0};
    vt[5] = '{2, 32'd9, 64'h0000_0000_0000_FE00, 1'b0,
              8'd1, 8'd1, 64'h0};
    exp_sent = 0;
    exp_drop = 0;

    #12;
    check("rst_val", 64'(noc_out_val), 64'd0);
    check("rst_data", noc_out_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_bad_tile), 64'd0);
    check("rst_sent", 64'(pkt_sent_cnt), 64'd0);
    check("rst_drop", 64'(pkt_drop_cnt), 64'd0);
    nxt();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      nxt();
      req_val = '0;
      req_val[vt[i].ri] = 1'b1;
      req_tileid[32*vt[i].ri +: 32] = vt[i].tile;
      req_data[64*vt[i].ri +: 64] = vt[i].data;
      eg = 4'b0001 << vt[i].ri;
      @(negedge clk);
      check($sformatf("v%0d_grant", i), 64'(req_rdy), 64'(eg));
      nxt();
      req_val = '0;
      @(negedge clk);
      if (vt[i].bad) begin
        exp_drop++;
        check($sformatf("v%0d_err", i), 64'(err_bad_tile), 64'd1);
        check($sformatf("v%0d_noval", i), 64'(noc_out_val), 64'd0);
        check($sformatf("v%0d_drop", i), 64'(pkt_drop_cnt),
              64'(exp_drop));
        nxt();
        @(negedge clk);
        check($sformatf("v%0d_errpulse", i), 64'(err_bad_tile), 64'd0);
      end else begin
        check($sformatf("v%0d_hval", i), 64'(noc_out_val), 64'd1);
        check($sformatf("v%0d_hdr", i), noc_out_data,
              hdr(vt[i].x, vt[i].y));
        check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
        nxt();
        @(negedge clk);
        check($sformatf("v%0d_pld", i), noc_out_data, vt[i].pld);
        nxt();
        exp_sent++;
        @(negedge clk);
        check($sformatf("v%0d_done", i), 64'(noc_out_val), 64'd0);
        check($sformatf("v%0d_sent", i), 64'(pkt_sent_cnt),
              64'(exp_sent));
      end
    end

    // Backpressure on header then payload.
    nxt();
    noc_out_rdy = 1'b0;
    req_val = 4'b0100;
    req_tileid[64 +: 32] = 32'd10;
    req_data[128 +: 64] = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check("bp_grant", 64'(req_rdy), 64'h4);
    nxt();
    req_val = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_hval", 64'(noc_out_val), 64'd1);
      check("bp_hdr", noc_out_data, hdr(8'd2, 8'd1));
      check("bp_hrdy", 64'(req_rdy), 64'd0);
      nxt();
    end
    noc_out_rdy = 1'b1;
    @(negedge clk);
    check("bp_hdr_last", noc_out_data, hdr(8'd2, 8'd1));
    nxt();
    noc_out_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_pval", 64'(noc_out_val), 64'd1);
      check("bp_pld", noc_out_data, 64'h0123_4567_89AB_01EF);
      check("bp_prdy", 64'(req_rdy), 64'd0);
      nxt();
    end
    noc_out_rdy = 1'b1;
    req_val = '0;
    @(negedge clk);
    check("bp_pld_last", noc_out_data, 64'h0123_4567_89AB_01EF);
    nxt();
    exp_sent++;
    @(negedge clk);
    check("bp_done", 64'(noc_out_val), 64'd0);
    check("bp_sent", 64'(pkt_sent_cnt), 64'(exp_sent));
    check("bp_flits", 64'(flit_cnt), 64'(2 * exp_sent));

    // Reset while stalled in payload.
    nxt();
    req_val = 4'b0010;
    req_tileid[32 +: 32] = 32'd5;
    req_data[64 +: 64] = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    check("rs_grant", 64'(req_rdy), 64'h2);
    nxt();
    req_val = '0;
    nxt();
    noc_out_rdy = 1'b0;
    @(negedge clk);
    check("rs_pld", noc_out_data, 64'hAAAA_BBBB_CCCC_01DD);
    nxt();
    rst_n = 1'b0;
    #2;
    check("rs_val", 64'(noc_out_val), 64'd0);
    check("rs_data", noc_out_data, 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_sent", 64'(pkt_sent_cnt), 64'd0);
    check("rs_drop", 64'(pkt_drop_cnt), 64'd0);
    check("rs_rdy", 64'(req_rdy), 64'd0);
    nxt();
    nxt();
    rst_n = 1'b1;
    noc_out_rdy = 1'b1;

    // Fairness with all requesters held; pointer restarts at 0.
    for (int i = 0; i < 4; i++) begin
      req_tileid[32*i +: 32] = 32'(9 * i + 1);
      req_data[64*i +: 64] = 64'hCAFE_F00D_DEAD_BEEF;
      gcount[i] = 0;
    end
    req_val = 4'b1111;
    for (int p = 0; p < 12; p++) begin
      @(negedge clk);
      eg = 4'b0001 << (p % 4);
      check($sformatf("fa_grant%0d", p), 64'(req_rdy), 64'(eg));
      for (int i = 0; i < 4; i++)
        if (req_rdy[i]) gcount[i]++;
      nxt();
      @(negedge clk);
      check($sformatf("fa_hdr%0d", p), noc_out_data,
            hdr(8'((p % 4) + 1), 8'(p % 4)));
      nxt();
      @(negedge clk);
      check($sformatf("fa_pld%0d", p), noc_out_data,
            64'hCAFE_F00D_DEAD_00EF);
      nxt();
    end
    req_val = '0;
    for (int i = 0; i < 4; i++)
      check($sformatf("fa_cnt%0d", i), 64'(gcount[i]), 64'd3);
    @(negedge clk);
    check("fa_sent", 64'(pkt_sent_cnt), 64'd12);
    check("fa_flits", 64'(flit_cnt), 64'd24);

    // Saturation of a 4-bit counter over 20 packets.
    s_req_val = 4'b0001;
    repeat (60) nxt();
    s_req_val = '0;
    repeat (3) nxt();
    @(negedge clk);
    check("sat_sent", 64'(s_sent), 64'd15);
    check("sat_flits", 64'(s_flit_cnt), 64'd40);
    check("sat_idle", 64'(s_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
